// File: rtl/spmv_op_sequencer_pkg.sv
// Shared definitions for the PE op-chain sequencer: op-word field layout,
// opcode values, sequencer state encodings and the command-queue entry.
package spmv_op_sequencer_pkg;

  localparam int OPC_W   = 3;
  localparam int PEID_W  = 4;
  localparam int ARG1_W  = 4;
  localparam int DATA_W  = 52;
  localparam int OP_W    = 64;

  localparam logic [OPC_W-1:0] OP_NOP    = 3'd0;
  localparam logic [OPC_W-1:0] OP_RST    = 3'd1;
  localparam logic [OPC_W-1:0] OP_LD     = 3'd2;
  localparam logic [OPC_W-1:0] OP_STEADY = 3'd3;

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_DRAIN     = 2'd1;
  localparam logic [1:0] ST_WAIT_IDLE = 2'd2;

  // Field order matches the PE chain: [63:12] data, [11:8] arg1, [7] bcast,
  // [6:3] PE id, [2:0] opcode.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ARG1_W-1:0] arg1;
    logic              bcast;
    logic [PEID_W-1:0] pe_id;
    logic [OPC_W-1:0]  opcode;
  } op_t;

  typedef struct packed {
    logic barrier;
    op_t  op;
  } cmd_entry_t;

  localparam int CMD_W = $bits(cmd_entry_t);

  function automatic logic op_is_nop(input op_t op);
    return op == '0;
  endfunction

endpackage

// File: rtl/std_fifo.sv
// Generic first-word-fall-through FIFO; head data is valid whenever o_empty is low.
// DEPTH must be a power of two >= 2; push while full and pop while empty are ignored.
module std_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  output logic             o_full,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_pop_dat,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/spmv_op_sequencer.sv
// Feeds host commands into the PE op chain at up to one op per cycle and
// resolves barriers by draining the chain then waiting for busy to settle low.
module spmv_op_sequencer
  import spmv_op_sequencer_pkg::*;
#(
  parameter int NUM_PE         = 4,
  parameter int CMD_DEPTH      = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic        cmd_wait,
  input  logic [63:0] cmd_op,
  output logic        cmd_ready,
  output logic [63:0] op_out,
  input  logic        busy_in,
  output logic        idle,
  output logic        barrier_done,
  output logic        timeout_err,
  output logic [31:0] ops_issued
);

  localparam int DRAIN_LOAD = 2 * NUM_PE + 2;
  localparam int DRAIN_W    = $clog2(DRAIN_LOAD + 1);
  localparam int SETTLE_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int TMO_W      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DRAIN_W-1:0]  DRAIN_INIT = DRAIN_W'(DRAIN_LOAD);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SETTLE_CYCLES);
  localparam logic [TMO_W-1:0]    TMO_MAX    = TMO_W'(TIMEOUT_CYCLES);

  logic [1:0]          r_state;
  op_t                 r_op;
  logic [DRAIN_W-1:0]  r_drain;
  logic [SETTLE_W-1:0] r_settle;
  logic [TMO_W-1:0]    r_tmo;
  logic                r_idle;
  logic                r_done;
  logic                r_err;
  logic [31:0]         r_ops;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  cmd_entry_t          w_push_dat;
  logic [CMD_W-1:0]    w_head_raw;
  cmd_entry_t          w_head;
  logic [SETTLE_W-1:0] w_settle_nxt;
  logic [TMO_W-1:0]    w_tmo_nxt;

  assign cmd_ready          = !w_full && rst_n;
  assign w_push             = cmd_valid && cmd_ready;
  assign w_push_dat.barrier = cmd_wait;
  assign w_push_dat.op      = cmd_op;
  assign w_head             = w_head_raw;
  // Head is consumed in RUN whether it is an op or a barrier.
  assign w_pop              = (r_state == ST_RUN) && !w_empty;

  std_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .o_full     (w_full),
    .i_pop      (w_pop),
    .o_pop_dat  (w_head_raw),
    .o_empty    (w_empty)
  );

  assign w_settle_nxt = busy_in ? '0 : r_settle + 1'b1;
  assign w_tmo_nxt    = (r_tmo == TMO_MAX) ? r_tmo : r_tmo + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_op     <= '0;
      r_drain  <= '0;
      r_settle <= '0;
      r_tmo    <= '0;
      r_idle   <= 1'b1;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_ops    <= '0;
    end else begin
      r_op   <= '0;
      r_done <= 1'b0;
      r_idle <= w_empty && (r_state == ST_RUN) && !busy_in;
      case (r_state)
        ST_RUN: begin
          if (!w_empty) begin
            if (w_head.barrier) begin
              r_state <= ST_DRAIN;
              r_drain <= DRAIN_INIT;
            end else begin
              r_op <= w_head.op;
              if (!op_is_nop(w_head.op)) r_ops <= r_ops + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          r_drain <= r_drain - 1'b1;
          if (r_drain == DRAIN_W'(1)) begin
            r_state  <= ST_WAIT_IDLE;
            r_settle <= '0;
            r_tmo    <= '0;
          end
        end
        ST_WAIT_IDLE: begin
          r_settle <= w_settle_nxt;
          r_tmo    <= w_tmo_nxt;
          if (w_tmo_nxt == TMO_MAX) r_err <= 1'b1;
          // Returning to RUN here lets the next entry pop in the pulse cycle.
          if (w_settle_nxt == SETTLE_MAX) begin
            r_done  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign op_out       = r_op;
  assign idle         = r_idle;
  assign barrier_done = r_done;
  assign timeout_err  = r_err;
  assign ops_issued   = r_ops;

  a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
    barrier_done |=> !barrier_done);

endmodule

// File: tb/tb_spmv_op_sequencer.sv
// Directed scenarios plus randomized traffic, checked each cycle against a queue-based model.
module tb_spmv_op_sequencer;

  localparam int NUM_PE    = 4;
  localparam int CMD_DEPTH = 8;
  localparam int SETTLE    = 4;
  localparam int TMO       = 16;
  localparam int DRAIN     = 2 * NUM_PE + 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_wait;
  logic [63:0] cmd_op;
  logic        cmd_ready;
  logic [63:0] op_out;
  logic        busy_in;
  logic        idle;
  logic        barrier_done;
  logic        timeout_err;
  logic [31:0] ops_issued;

  always #5 clk = ~clk;

  spmv_op_sequencer #(
    .NUM_PE         (NUM_PE),
    .CMD_DEPTH      (CMD_DEPTH),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_wait     (cmd_wait),
    .cmd_op       (cmd_op),
    .cmd_ready    (cmd_ready),
    .op_out       (op_out),
    .busy_in      (busy_in),
    .idle         (idle),
    .barrier_done (barrier_done),
    .timeout_err  (timeout_err),
    .ops_issued   (ops_issued)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a command queue plus a phase (flowing / draining until a
  // known edge / waiting for a run of low busy cycles).
  logic [64:0] mq[$];
  int          m_phase;
  int          m_edge;
  int          m_wait_from;
  int          m_low_run;
  int          m_waited;
  logic [63:0] m_op;
  logic        m_idle;
  logic        m_done;
  logic        m_err;
  logic [31:0] m_ops;
  bit          m_live = 0;

  always @(posedge clk) begin
    logic        acc;
    logic [64:0] e;
    m_edge++;
    if (!rst_n) begin
      mq.delete();
      m_phase = 0;
      m_op    = '0;
      m_idle  = 1'b1;
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_ops   = '0;
    end else begin
      acc    = cmd_valid && (mq.size() < CMD_DEPTH);
      m_idle = (mq.size() == 0) && (m_phase == 0) && !busy_in;
      m_op   = '0;
      m_done = 1'b0;
      if (m_phase == 0) begin
        if (mq.size() > 0) begin
          e = mq.pop_front();
          if (e[64]) begin
            m_phase     = 1;
            m_wait_from = m_edge + DRAIN;
          end else begin
            m_op = e[63:0];
            if (e[63:0] != 64'd0) m_ops = m_ops + 1;
          end
        end
      end else if (m_phase == 1) begin
        if (m_edge == m_wait_from) begin
          m_phase   = 2;
          m_low_run = 0;
          m_waited  = 0;
        end
      end else begin
        if (m_waited < TMO) m_waited++;
        if (m_waited == TMO) m_err = 1'b1;
        m_low_run = busy_in ? 0 : m_low_run + 1;
        if (m_low_run == SETTLE) begin
          m_done  = 1'b1;
          m_phase = 0;
        end
      end
      if (acc) mq.push_back({cmd_wait, cmd_op});
    end
    m_live = 1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("op_out", op_out, m_op);
      check("cmd_ready", {63'd0, cmd_ready}, {63'd0, rst_n && (mq.size() < CMD_DEPTH)});
      check("idle", {63'd0, idle}, {63'd0, m_idle});
      check("barrier_done", {63'd0, barrier_done}, {63'd0, m_done});
      check("timeout_err", {63'd0, timeout_err}, {63'd0, m_err});
      check("ops_issued", {32'd0, ops_issued}, {32'd0, m_ops});
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int k);
    k = 0;
    while (k < budget) begin
      tick();
      k++;
      if (barrier_done) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_done: no barrier_done within %0d cycles", budget);
    k = -1;
  endtask

  task automatic push_barrier();
    cmd_valid = 1'b1;
    cmd_wait  = 1'b1;
    cmd_op    = {$urandom, $urandom};
    tick();
    cmd_valid = 1'b0;
    cmd_wait  = 1'b0;
  endtask

  int          k;
  int          got;
  int          acc_cnt;
  int          seen;
  logic        rdy;
  logic [63:0] fill_ops [9];
  int          pat [8] = '{1, 0, 0, 1, 0, 0, 0, 0};

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wait = 1'b0; cmd_op = '0; busy_in = 1'b0;
    repeat (3) tick();
    check("rst_op_out", op_out, 64'd0);
    check("rst_idle", {63'd0, idle}, 64'd1);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_ops", {32'd0, ops_issued}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Three ops back-to-back into an empty queue.
    cmd_valid = 1'b1; cmd_op = 64'h1002;
    tick();
    check("lat_t0", op_out, 64'd0);
    cmd_op = 64'h2003;
    tick();
    check("lat_t1", op_out, 64'h1002);
    cmd_op = 64'h3002;
    tick();
    check("lat_t2", op_out, 64'h2003);
    cmd_valid = 1'b0;
    tick();
    check("lat_t3", op_out, 64'h3002);
    check("lat_cnt", {32'd0, ops_issued}, 64'd3);
    tick();
    check("lat_t4", op_out, 64'd0);
    repeat (3) tick();

    // Barrier with busy low: 10 drain + 4 settle + 1.
    push_barrier();
    wait_done(60, k);
    check("bar_lat", 64'(k), 64'd15);
    tick();
    check("bar_pulse_len", {63'd0, barrier_done}, 64'd0);

    // Settle restart on a busy glitch.
    push_barrier();
    got = -1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (barrier_done) begin got = c; break; end
      busy_in = (c >= 11 && c < 19) ? pat[c-11][0] : 1'b0;
    end
    busy_in = 1'b0;
    check("bar_glitch", 64'(got), 64'd19);
    repeat (2) tick();

    // Fill the queue behind a blocked barrier.
    for (int i = 0; i < 9; i++) fill_ops[i] = {$urandom, $urandom} | 64'd1;
    push_barrier();
    busy_in = 1'b1;
    acc_cnt = 0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 30 && acc_cnt < 9; i++) begin
      cmd_op = fill_ops[acc_cnt];
      rdy = cmd_ready;
      tick();
      if (rdy) acc_cnt++;
    end
    check("fill_acc", 64'(acc_cnt), 64'd8);
    check("fill_ready", {63'd0, cmd_ready}, 64'd0);
    busy_in = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      rdy = cmd_ready;
      tick();
      if (rdy && acc_cnt < 9) begin
        acc_cnt++;
        cmd_valid = 1'b0;
      end
      if (op_out != 64'd0) seen++;
    end
    cmd_valid = 1'b0;
    check("fill_out_cnt", 64'(seen), 64'd9);
    check("fill_acc_all", 64'(acc_cnt), 64'd9);

    // Reset mid-WAIT_IDLE with three ops queued.
    push_barrier();
    busy_in = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_op = {$urandom, $urandom} | 64'd1;
      tick();
    end
    cmd_valid = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; busy_in = 1'b0;
    #1;
    check("rr_op_out", op_out, 64'd0);
    check("rr_idle", {63'd0, idle}, 64'd1);
    check("rr_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("rr_ops", {32'd0, ops_issued}, 64'd0);
    check("rr_done", {63'd0, barrier_done}, 64'd0);
    check("rr_err", {63'd0, timeout_err}, 64'd0);
    tick();
    check("rr_flushed", op_out, 64'd0);
    repeat (2) tick();

    // Timeout with busy stuck high, then release.
    push_barrier();
    busy_in = 1'b1;
    got = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (timeout_err && got < 0) got = c;
    end
    check("tmo_rise", 64'(got), 64'd27);
    busy_in = 1'b0;
    wait_done(20, k);
    check("tmo_release", 64'(k), 64'd4);
    check("tmo_sticky", {63'd0, timeout_err}, 64'd1);
    repeat (3) tick();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 399) != 0);
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_wait  = ($urandom_range(0, 9) == 0);
      cmd_op    = ($urandom_range(0, 15) == 0) ? 64'd0 : {$urandom, $urandom};
      busy_in   = ($urandom_range(0, 3) == 0);
      tick();
    end
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_wait = 1'b0; busy_in = 1'b0;
    repeat (60) tick();
    check("final_idle", {63'd0, idle}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
